// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the core-side memory bus arbiter.
// The port-id width and named requester ids follow the default three-port configuration.
package mem_arb_pkg;

    localparam int NUM_PORTS_DEFAULT = 3;
    localparam int PORT_ID_WIDTH     = $clog2(NUM_PORTS_DEFAULT);

    typedef logic [PORT_ID_WIDTH-1:0] port_id_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RESP
    } arb_state_t;

    localparam port_id_t PORT_FETCH = port_id_t'(0);
    localparam port_id_t PORT_LOAD  = port_id_t'(1);
    localparam port_id_t PORT_STORE = port_id_t'(2);

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: scans the request vector starting one past last_grant
// and returns the first requester as a one-hot grant plus its index.
module rr_priority_picker #(
    parameter int NUM_PORTS = 3,
    parameter int IDX_WIDTH = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_WIDTH-1:0] last_grant,
    output logic [NUM_PORTS-1:0] grant,
    output logic [IDX_WIDTH-1:0] grant_idx,
    output logic                 grant_valid
);

    logic [IDX_WIDTH-1:0] cand;

    // The most recent winner is visited last, so every waiting port gets a turn.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand        = '0;
        for (int off = 1; off <= NUM_PORTS; off++) begin
            cand = IDX_WIDTH'((int'(last_grant) + off) % NUM_PORTS);
            if (!grant_valid && req[cand]) begin
                grant[cand] = 1'b1;
                grant_idx   = cand;
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/memory_bus_arbiter.sv
// Round-robin arbiter sharing one memory bus between fetch, load and store, one
// transaction at a time, with a watchdog that aborts a response that never arrives.
module memory_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_PORTS      = NUM_PORTS_DEFAULT,
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 64,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_PORTS-1:0]            req_valid,
    input  logic [NUM_PORTS-1:0]            req_write,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_PORTS-1:0]            req_ready,
    output logic [NUM_PORTS-1:0]            resp_valid,
    output logic [DATA_WIDTH-1:0]           resp_rdata,
    output logic                            mem_req_valid,
    input  logic                            mem_req_ready,
    output logic                            mem_req_write,
    output logic [ADDR_WIDTH-1:0]           mem_req_addr,
    output logic [DATA_WIDTH-1:0]           mem_req_wdata,
    input  logic                            mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]           mem_resp_rdata,
    output logic                            timeout_error
);

    localparam int IDX_WIDTH = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES);

    arb_state_t           state;
    logic [IDX_WIDTH-1:0] last_grant;
    logic [IDX_WIDTH-1:0] owner;
    logic [CNT_WIDTH-1:0] wd_count;

    logic [NUM_PORTS-1:0] grant;
    logic [IDX_WIDTH-1:0] grant_idx;
    logic                 grant_valid;

    logic [ADDR_WIDTH-1:0] addr_arr  [NUM_PORTS];
    logic [DATA_WIDTH-1:0] wdata_arr [NUM_PORTS];

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_unpack
        assign addr_arr[i]  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_arr[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_priority_picker #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_picker (
        .req         (req_valid),
        .last_grant  (last_grant),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // A grant during reset would never be latched, so it must not be signalled either.
    assign req_ready = (state == IDLE && !reset) ? grant : '0;

    function automatic logic [NUM_PORTS-1:0] to_onehot(input logic [IDX_WIDTH-1:0] idx);
        logic [NUM_PORTS-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            last_grant    <= IDX_WIDTH'(NUM_PORTS - 1);
            owner         <= '0;
            wd_count      <= '0;
            resp_valid    <= '0;
            resp_rdata    <= '0;
            mem_req_valid <= 1'b0;
            mem_req_write <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wdata <= '0;
            timeout_error <= 1'b0;
        end else begin
            resp_valid <= '0;
            resp_rdata <= '0;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        owner         <= grant_idx;
                        last_grant    <= grant_idx;
                        mem_req_write <= req_write[grant_idx];
                        mem_req_addr  <= addr_arr[grant_idx];
                        mem_req_wdata <= wdata_arr[grant_idx];
                        mem_req_valid <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        wd_count      <= '0;
                        state         <= WAIT_RESP;
                    end
                end
                WAIT_RESP: begin
                    wd_count <= wd_count + 1'b1;
                    // A response in the final watchdog cycle still counts as a normal completion.
                    if (mem_resp_valid) begin
                        resp_valid <= to_onehot(owner);
                        resp_rdata <= mem_req_write ? '0 : mem_resp_rdata;
                        state      <= IDLE;
                    end else if (wd_count == CNT_WIDTH'(TIMEOUT_CYCLES - 1)) begin
                        resp_valid    <= to_onehot(owner);
                        timeout_error <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Directed bench for memory_bus_arbiter: single read, round-robin contention, backpressure,
// watchdog timeout, response-beats-timeout and reset in the middle of a transaction.
module tb_memory_bus_arbiter;
    import mem_arb_pkg::*;

    localparam int NP = 3;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int TO = 4;

    logic             clk;
    logic             reset;
    logic [NP-1:0]    req_valid;
    logic [NP-1:0]    req_write;
    logic [NP*AW-1:0] req_addr;
    logic [NP*DW-1:0] req_wdata;
    logic [NP-1:0]    req_ready;
    logic [NP-1:0]    resp_valid;
    logic [DW-1:0]    resp_rdata;
    logic             mem_req_valid;
    logic             mem_req_ready;
    logic             mem_req_write;
    logic [AW-1:0]    mem_req_addr;
    logic [DW-1:0]    mem_req_wdata;
    logic             mem_resp_valid;
    logic [DW-1:0]    mem_resp_rdata;
    logic             timeout_error;

    int checks = 0;
    int errors = 0;

    memory_bus_arbiter #(
        .NUM_PORTS      (NP),
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_write      (req_write),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_ready      (req_ready),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_write  (mem_req_write),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wdata  (mem_req_wdata),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_rdata (mem_resp_rdata),
        .timeout_error  (timeout_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached before the sequence ended");
        $fatal(1, "[TB] simulation time limit");
    end

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input int p, input logic v, input logic w,
                                  input logic [63:0] a, input logic [63:0] d);
        req_valid[p]           = v;
        req_write[p]           = w;
        req_addr[p*AW +: AW]   = a;
        req_wdata[p*DW +: DW]  = d;
    endtask

    task automatic clear_inputs();
        req_valid      = '0;
        req_write      = '0;
        req_addr       = '0;
        req_wdata      = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_rdata = '0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    int order [6] = '{0, 1, 2, 0, 1, 2};
    int p;

    initial begin
        // Reset values, with every port requesting while reset is held.
        clear_inputs();
        reset = 1'b1;
        req_valid = 3'b111;
        req_addr  = {64'h30, 64'h20, 64'h10};
        cyc();
        cyc();
        check_output("rst_req_ready",     64'(req_ready),     64'(0));
        check_output("rst_resp_valid",    64'(resp_valid),    64'(0));
        check_output("rst_resp_rdata",    64'(resp_rdata),    64'(0));
        check_output("rst_mem_req_valid", 64'(mem_req_valid), 64'(0));
        check_output("rst_mem_req_write", 64'(mem_req_write), 64'(0));
        check_output("rst_mem_req_addr",  64'(mem_req_addr),  64'(0));
        check_output("rst_mem_req_wdata", 64'(mem_req_wdata), 64'(0));
        check_output("rst_timeout_error", 64'(timeout_error), 64'(0));

        // Single read: best-case latency from port 0.
        clear_inputs();
        reset = 1'b0;
        apply_stimulus(int'(PORT_FETCH), 1'b1, 1'b0, 64'h100, 64'h0);
        #1;
        check_output("rd_req_ready_c0", 64'(req_ready), 64'(3'b001));
        cyc();
        req_valid = '0;
        mem_req_ready = 1'b1;
        #1;
        check_output("rd_mem_valid_c1", 64'(mem_req_valid), 64'(1));
        check_output("rd_mem_addr_c1",  64'(mem_req_addr),  64'h100);
        check_output("rd_mem_write_c1", 64'(mem_req_write), 64'(0));
        check_output("rd_req_ready_c1", 64'(req_ready),     64'(0));
        cyc();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 64'hDEADBEEF;
        #1;
        check_output("rd_mem_valid_c2",  64'(mem_req_valid), 64'(0));
        check_output("rd_resp_valid_c2", 64'(resp_valid),    64'(0));
        cyc();
        mem_resp_valid = 1'b0;
        #1;
        check_output("rd_resp_valid_c3", 64'(resp_valid), 64'(3'b001));
        check_output("rd_resp_rdata_c3", 64'(resp_rdata), 64'hDEADBEEF);
        cyc();
        #1;
        check_output("rd_resp_pulse_c4", 64'(resp_valid), 64'(0));

        // Contention: all ports request continuously; grants rotate 0,1,2,0,1,2.
        apply_reset();
        for (int i = 0; i < NP; i++) begin
            apply_stimulus(i, 1'b1, 1'b0, 64'h1000 + 64'(i * 16), 64'h0);
        end
        #1;
        for (int k = 0; k < 6; k++) begin
            p = order[k];
            check_output($sformatf("cont_ready_%0d", k), 64'(req_ready), 64'(3'b001 << p));
            cyc();
            mem_req_ready = 1'b1;
            #1;
            check_output($sformatf("cont_addr_%0d", k), 64'(mem_req_addr), 64'h1000 + 64'(p * 16));
            cyc();
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b1;
            mem_resp_rdata = 64'hA0 + 64'(k);
            cyc();
            mem_resp_valid = 1'b0;
            #1;
            check_output($sformatf("cont_resp_valid_%0d", k), 64'(resp_valid), 64'(3'b001 << p));
            check_output($sformatf("cont_resp_rdata_%0d", k), 64'(resp_rdata), 64'hA0 + 64'(k));
        end
        req_valid = '0;

        // Backpressure: port 2 write held off by memory for 5 cycles.
        apply_reset();
        apply_stimulus(int'(PORT_STORE), 1'b1, 1'b1, 64'h200, 64'h55);
        #1;
        check_output("bp_req_ready", 64'(req_ready), 64'(3'b100));
        cyc();
        req_valid = '0;
        for (int i = 0; i < 6; i++) begin
            mem_req_ready = (i == 5);
            #1;
            check_output($sformatf("bp_valid_%0d", i), 64'(mem_req_valid), 64'(1));
            check_output($sformatf("bp_write_%0d", i), 64'(mem_req_write), 64'(1));
            check_output($sformatf("bp_addr_%0d", i),  64'(mem_req_addr),  64'h200);
            check_output($sformatf("bp_wdata_%0d", i), 64'(mem_req_wdata), 64'h55);
            cyc();
        end
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 64'hFFFF;
        cyc();
        mem_resp_valid = 1'b0;
        #1;
        check_output("bp_resp_valid", 64'(resp_valid),    64'(3'b100));
        check_output("bp_resp_rdata", 64'(resp_rdata),    64'(0));
        check_output("bp_no_timeout", 64'(timeout_error), 64'(0));

        // Timeout: memory never answers; abort lands TO+1 cycles after the handshake.
        apply_reset();
        apply_stimulus(int'(PORT_LOAD), 1'b1, 1'b0, 64'h300, 64'h0);
        #1;
        check_output("to_req_ready", 64'(req_ready), 64'(3'b010));
        cyc();
        req_valid = '0;
        mem_req_ready = 1'b1;
        cyc();
        mem_req_ready = 1'b0;
        for (int c = 1; c <= TO; c++) begin
            #1;
            check_output($sformatf("to_quiet_%0d", c), 64'(resp_valid), 64'(0));
            cyc();
        end
        #1;
        check_output("to_err_before", 64'(timeout_error), 64'(1));
        check_output("to_resp_valid", 64'(resp_valid),    64'(3'b010));
        check_output("to_resp_rdata", 64'(resp_rdata),    64'(0));
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 64'h77;
        cyc();
        mem_resp_valid = 1'b0;
        #1;
        check_output("to_late_ignored", 64'(resp_valid),    64'(0));
        check_output("to_err_sticky",   64'(timeout_error), 64'(1));
        check_output("to_no_issue",     64'(mem_req_valid), 64'(0));
        cyc();
        #1;
        check_output("to_late_ignored2", 64'(resp_valid), 64'(0));

        // Response in the last watchdog cycle wins over the timeout.
        apply_reset();
        #1;
        check_output("edge_err_cleared", 64'(timeout_error), 64'(0));
        apply_stimulus(int'(PORT_FETCH), 1'b1, 1'b0, 64'h400, 64'h0);
        cyc();
        req_valid = '0;
        mem_req_ready = 1'b1;
        cyc();
        mem_req_ready = 1'b0;
        cyc();
        cyc();
        cyc();
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 64'h1234;
        cyc();
        mem_resp_valid = 1'b0;
        #1;
        check_output("edge_resp_valid", 64'(resp_valid),    64'(3'b001));
        check_output("edge_resp_rdata", 64'(resp_rdata),    64'h1234);
        check_output("edge_no_error",   64'(timeout_error), 64'(0));

        // Reset while waiting for a response: the transaction and its late response vanish.
        apply_reset();
        apply_stimulus(int'(PORT_LOAD), 1'b1, 1'b0, 64'h500, 64'h0);
        #1;
        check_output("mid_req_ready", 64'(req_ready), 64'(3'b010));
        cyc();
        req_valid = '0;
        mem_req_ready = 1'b1;
        cyc();
        mem_req_ready = 1'b0;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 64'h99;
        apply_stimulus(int'(PORT_FETCH), 1'b1, 1'b0, 64'h600, 64'h0);
        apply_stimulus(int'(PORT_LOAD),  1'b1, 1'b0, 64'h500, 64'h0);
        #1;
        check_output("mid_resp_valid", 64'(resp_valid),    64'(0));
        check_output("mid_resp_rdata", 64'(resp_rdata),    64'(0));
        check_output("mid_mem_valid",  64'(mem_req_valid), 64'(0));
        check_output("mid_mem_addr",   64'(mem_req_addr),  64'(0));
        check_output("mid_error",      64'(timeout_error), 64'(0));
        check_output("mid_next_grant", 64'(req_ready),     64'(3'b001));
        cyc();
        mem_resp_valid = 1'b0;
        req_valid = '0;
        #1;
        check_output("mid_resp_after", 64'(resp_valid),    64'(0));
        check_output("mid_issue_valid", 64'(mem_req_valid), 64'(1));
        check_output("mid_issue_addr", 64'(mem_req_addr),  64'h600);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
